spi_frame_scheduler: RTL
========================

# spi_frame_scheduler

Arbitration and sequencing controller in front of the SPI slave link. It accepts 40-bit sensor frames from two producers (humidity block and a second sensor block) using a valid/ready handshake, and grants them round-robin. It presents the granted frame to the SPI slave's parallel transmit input and holds it stable for the whole chip-select window. After each transaction it captures the slave's 88-bit receive register and keeps link statistics.

## Interface
Parameters:
- `LOAD_TIMEOUT`, default 50_000_000: cycles a loaded frame may wait for a transaction before it is discarded; 0 disables the timeout.
- `IDLE_FRAME`, default 40'h0: value driven on `tx_frame` when no frame is loaded.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ssel`  in  1  raw SPI chip select, active low, asynchronous to `clk`.
- `src0_valid`  in  1  humidity frame available.
- `src0_data`  in  40  humidity frame.
- `src0_ready`  out  1  frame accepted when high together with `src0_valid`.
- `src1_valid` / `src1_data` / `src1_ready`: same as `src0_*`, for the second sensor.
- `rx_frame`  in  88  receive shift register of the SPI slave.
- `tx_frame`  out  40  parallel transmit frame to the SPI slave.
- `tx_tag`  out  1  source of the currently loaded frame.
- `rx_data`  out  88  `rx_frame` captured at end of transaction.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` updated.
- `busy`  out  1  high whenever the state is not IDLE.
- `frames_sent`  out  16  saturating count of transactions that carried a loaded frame.
- `empty_reads`  out  8  saturating count of transactions with no frame loaded.

## Operation
- Chip-select synchronizer: `ssel` passes through a 3-flop chain `sr[2:0]`.
  - Active = `~sr[1]`.
  - Start = `sr[2:1]==2'b10`.
  - End = `sr[2:1]==2'b01`.
  - Same alignment as the slave's own synchronizer.
- States:
  - IDLE: no frame loaded; `tx_frame = IDLE_FRAME`.
    - Granted source's `ready = ~active`; the other ready is 0.
    - valid&&ready transfers the frame and goes to LOADED.
    - Start in IDLE goes to ACTIVE_EMPTY.
  - LOADED: `tx_frame` and `tx_tag` hold the accepted frame.
    - Start goes to ACTIVE.
    - Timeout counter reaching `LOAD_TIMEOUT-1` goes to IDLE, drops the frame and leaves the RR pointer unchanged.
  - ACTIVE / ACTIVE_EMPTY: `tx_frame` frozen; both readys 0. End goes to DONE.
  - DONE, 1 cycle:
    - `rx_data <= rx_frame`; pulse `rx_valid`.
    - Increment `frames_sent` (from ACTIVE) or `empty_reads` (from ACTIVE_EMPTY).
    - Return to IDLE.
- Round-robin:
  - `last` pointer records the source of the last accepted frame.
  - Grant goes to `~last` if that source is valid, otherwise to `last`.
  - Grant is evaluated combinationally in IDLE.
  - `last` updates only on a transfer.
- Counters saturate at all-ones; they do not wrap.
- Timeout counter is at least 26 bits wide; it clears on entry to LOADED.

## Timing
- Reset values:
  - state IDLE.
  - `tx_frame = IDLE_FRAME`; `tx_tag = 0`; `last = 1`, so `src0` wins first.
  - `src0_ready`/`src1_ready`/`rx_valid`/`busy` = 0.
  - `rx_data = 0`; both counters 0; `sr = 3'b111`.
- Transfer to `tx_frame` visible: 1 cycle after valid&&ready.
- `ssel` pin falling to ACTIVE: 3 cycles. `ssel` rising to `rx_valid`: 4 cycles.
- Simultaneous events:
  - Start in the same cycle as a would-be transfer: no transfer occurs, because ready is already 0 once active.
  - Start in the same cycle as timeout expiry: start wins and the frame is sent.
- Any `src*_valid` change while not IDLE: ignored; the producer must hold its frame.
- `rst` asserted mid-transaction: immediate return to reset values. The slave sees `IDLE_FRAME` for the rest of that window; no `rx_valid`.
- End without a preceding start (glitch) in IDLE/LOADED: ignored.

## Configuration
- `SPI_SCHED_CMD_EN` defined: in DONE, `rx_frame[87:80]` is decoded as a command.
  - 8'h01: next grant forced to `src0`.
  - 8'h02: next grant forced to `src1`.
  - 8'hFF: both counters cleared.
  - Others: no effect.
  - A force applies to exactly one grant, and only if the forced source is valid; otherwise normal RR.
- Not defined: the command byte is ignored; arbitration is pure RR; counters clear only on `rst`.

## Test plan
- Reset, `src0_valid=1` with `40'hF555555555` -> `src0_ready` high cycle 0; `tx_frame=40'hF555555555`, `tx_tag=0` next cycle; `busy=1`.
- Both sources valid continuously, 4 transactions -> tags alternate 0,1,0,1; `frames_sent=4`.
- No source valid, one SSEL low/high -> `tx_frame=IDLE_FRAME` throughout; `empty_reads=1`; `rx_valid` pulses 4 cycles after `ssel` rises with `rx_data=rx_frame`.
- `LOAD_TIMEOUT=16`, frame loaded, no SSEL -> IDLE after 16 cycles; a new `src1` frame is accepted next.
- `src1_valid` rises while ACTIVE -> `src1_ready` stays 0 until DONE; `tx_frame` unchanged during SSEL low; `rst` pulse mid-window -> all outputs at reset values, no `rx_valid`.
- With `SPI_SCHED_CMD_EN`, `rx_frame[87:80]=8'h02`, both valid, `last=1` -> next grant `src1`; then 8'hFF -> both counters read 0 after DONE.

Source files
------------

// File: rtl/spi_frame_scheduler.sv
// Round-robin scheduler feeding 40-bit sensor frames to an SPI slave and capturing its 88-bit receive word.
// Optional command decode of the receive word is enabled by defining SPI_SCHED_CMD_EN.
module spi_frame_scheduler #(
    parameter int unsigned LOAD_TIMEOUT = 50_000_000,
    parameter logic [39:0] IDLE_FRAME   = 40'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ssel,
    input  logic        src0_valid,
    input  logic [39:0] src0_data,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [39:0] src1_data,
    output logic        src1_ready,
    input  logic [87:0] rx_frame,
    output logic [39:0] tx_frame,
    output logic        tx_tag,
    output logic [87:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic [7:0]  empty_reads,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LOADED       = 3'd1,
        ACTIVE       = 3'd2,
        ACTIVE_EMPTY = 3'd3,
        DONE         = 3'd4
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(LOAD_TIMEOUT) - 32'd1;

    state_t      state, state_n;
    logic [2:0]  sr;
    logic        active, sel_start, sel_end;
    logic        last;
    logic        grant, grant_valid, accept;
    logic        loaded_xfer;
    logic [31:0] tmo_cnt;
    logic        tmo_hit;
    logic [39:0] frame_q;
`ifdef SPI_SCHED_CMD_EN
    logic        force_pend;
    logic        force_src;
`endif

    // Same alignment as the slave's synchronizer, so start/end agree with its shift window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= 3'b111;
        else     sr <= {sr[1:0], ssel};
    end

    assign active    = ~sr[1];
    assign sel_start = (sr[2:1] == 2'b10);
    assign sel_end   = (sr[2:1] == 2'b01);
    assign tmo_hit   = (LOAD_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        grant = last;
        if (last ? src0_valid : src1_valid) grant = ~last;
`ifdef SPI_SCHED_CMD_EN
        if (force_pend && (force_src ? src1_valid : src0_valid)) grant = force_src;
`endif
    end

    // Handshake: a frame moves when src*_valid && src*_ready are both high at a rising clk edge.
    // Ready is offered only to the granted source, only in IDLE outside a chip-select window,
    // and only while that source is valid; producers must hold valid/data until accepted.
    assign grant_valid = grant ? src1_valid : src0_valid;
    assign accept      = (state == IDLE) && !active && grant_valid && !rst;
    assign src0_ready  = accept && !grant;
    assign src1_ready  = accept && grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (sel_start)   state_n = ACTIVE_EMPTY;
                else if (accept) state_n = LOADED;
            end
            LOADED: begin
                if (sel_start)    state_n = ACTIVE;
                else if (tmo_hit) state_n = IDLE;
            end
            ACTIVE, ACTIVE_EMPTY: begin
                if (sel_end) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q     <= '0;
            tx_tag      <= 1'b0;
            last        <= 1'b1;
            tmo_cnt     <= '0;
            loaded_xfer <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frames_sent <= '0;
            empty_reads <= '0;
`ifdef SPI_SCHED_CMD_EN
            force_pend  <= 1'b0;
            force_src   <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                frame_q <= grant ? src1_data : src0_data;
                tx_tag  <= grant;
                last    <= grant;
                tmo_cnt <= '0;
`ifdef SPI_SCHED_CMD_EN
                force_pend <= 1'b0;
`endif
            end else if (state == LOADED) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            if (sel_start && (state == IDLE || state == LOADED))
                loaded_xfer <= (state == LOADED);
            if (state == DONE) begin
                rx_data  <= rx_frame;
                rx_valid <= 1'b1;
                if (loaded_xfer) begin
                    if (frames_sent != 16'hFFFF) frames_sent <= frames_sent + 16'd1;
                end else begin
                    if (empty_reads != 8'hFF) empty_reads <= empty_reads + 8'd1;
                end
`ifdef SPI_SCHED_CMD_EN
                // A clear command overrides the increment of the same transaction.
                case (rx_frame[87:80])
                    8'h01: begin force_pend <= 1'b1; force_src <= 1'b0; end
                    8'h02: begin force_pend <= 1'b1; force_src <= 1'b1; end
                    8'hFF: begin frames_sent <= '0; empty_reads <= '0; end
                    default: ;
                endcase
`endif
            end
        end
    end

    assign tx_frame  = (state == LOADED || state == ACTIVE) ? frame_q : IDLE_FRAME;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
